// File: rtl/fpu_pkg.sv
// Shared binary32 FPU definitions: rounding-mode encodings, field geometry
// and the exception flag pair used by the conversion and arithmetic units.
package fpu_pkg;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RDN = 2'b10;
  localparam logic [1:0] RM_RUP = 2'b11;

  localparam int BIAS  = 127;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  typedef struct packed {
    logic nv;
    logic nx;
  } fpu_flags_t;

endpackage

// File: rtl/fpu_round_inc.sv
// Round-increment decision from lsb/guard/sticky, operand sign and rounding
// mode; shared by every FPU path that rounds a truncated magnitude.
module fpu_round_inc
  import fpu_pkg::*;
(
  input  logic       i_lsb,
  input  logic       i_guard,
  input  logic       i_sticky,
  input  logic       i_sign,
  input  logic [1:0] i_rm,
  output logic       o_inc
);

  // Increment selection per rounding mode
  always_comb begin
    o_inc = 1'b0;
    case (i_rm)
      RM_RNE:  o_inc = i_guard & (i_sticky | i_lsb);
      RM_RTZ:  o_inc = 1'b0;
      RM_RDN:  o_inc = i_sign & (i_guard | i_sticky);
      RM_RUP:  o_inc = ~i_sign & (i_guard | i_sticky);
      default: o_inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_ftoi_pipe.sv
// Two-stage binary32 -> OUT_W-bit integer converter with rounding, saturation
// and nv/nx flags; valid/ready on both sides, one op per cycle when unstalled.
module fpu_ftoi_pipe
  import fpu_pkg::*;
#(
  parameter int OUT_W     = 32,
  parameter bit FLUSH_SUB = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      x,
  input  logic [1:0]       rm,
  input  logic             uns,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] y,
  output logic             flag_nv,
  output logic             flag_nx
);

  // Aligned value keeps MAN_W+1 fraction bits: enough to hold the whole
  // significand for the smallest exponent that still reaches the guard bit.
  localparam int               WIDE_W  = OUT_W + MAN_W + 1;
  localparam logic [EXP_W:0]   OVF_EXP = (EXP_W + 1)'(BIAS + OUT_W);
  localparam logic [EXP_W-1:0] HALF_EXP = EXP_W'(BIAS - 1);
  localparam logic [OUT_W-1:0] SMAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SMIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] UMAX = {OUT_W{1'b1}};

  logic             r_s1_valid, r_s1_sign, r_s1_nan, r_s1_ovf;
  logic             r_s1_g, r_s1_s, r_s1_uns;
  logic [1:0]       r_s1_rm;
  logic [OUT_W-1:0] r_s1_int;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_y;
  fpu_flags_t       r_flags;

  logic             w_s1_adv;
  logic [EXP_W-1:0] w_exp;
  logic [MAN_W-1:0] w_man;
  logic [EXP_W-1:0] w_sh;
  logic [WIDE_W-1:0] w_wide;
  logic             w_nan, w_inf, w_nz;
  logic [OUT_W-1:0] w_int;
  logic             w_g, w_s, w_ovf;
  logic             w_inc, w_inexact, w_pos_ovf, w_neg_ovf;
  logic [OUT_W:0]   w_mag;
  logic [OUT_W-1:0] w_neg;
  logic [OUT_W-1:0] w_y;
  fpu_flags_t       w_flags;

  assign w_s1_adv  = ~r_out_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign flag_nv   = r_flags.nv;
  assign flag_nx   = r_flags.nx;

  assign w_exp  = x[MAN_W +: EXP_W];
  assign w_man  = x[MAN_W-1:0];
  assign w_sh   = w_exp - HALF_EXP;
  assign w_wide = {{OUT_W{1'b0}}, 1'b1, w_man} << w_sh;
  assign w_nan  = (w_exp == {EXP_W{1'b1}}) & (w_man != {MAN_W{1'b0}});
  assign w_inf  = (w_exp == {EXP_W{1'b1}}) & (w_man == {MAN_W{1'b0}});
  assign w_nz   = (w_exp != {EXP_W{1'b0}}) | ((w_man != {MAN_W{1'b0}}) & ~FLUSH_SUB);

  // Stage-1 decode/align: integer part, guard, sticky and overflow tag
  always_comb begin
    w_int = '0;
    w_g   = 1'b0;
    w_s   = 1'b0;
    w_ovf = 1'b0;
    if (w_nan | w_inf) begin
      w_ovf = w_inf;
    end else if (w_exp < HALF_EXP) begin
      w_s = w_nz;
    end else if ({1'b0, w_exp} >= OVF_EXP) begin
      w_ovf = 1'b1;
    end else begin
      w_int = w_wide[WIDE_W-1:MAN_W+1];
      w_g   = w_wide[MAN_W];
      w_s   = |w_wide[MAN_W-1:0];
    end
  end

  // Stage-1 register: loads whenever the slot is free or draining
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_nan   <= 1'b0;
      r_s1_ovf   <= 1'b0;
      r_s1_g     <= 1'b0;
      r_s1_s     <= 1'b0;
      r_s1_uns   <= 1'b0;
      r_s1_rm    <= 2'b00;
      r_s1_int   <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sign <= x[31];
        r_s1_nan  <= w_nan;
        r_s1_ovf  <= w_ovf;
        r_s1_g    <= w_g;
        r_s1_s    <= w_s;
        r_s1_uns  <= uns;
        r_s1_rm   <= rm;
        r_s1_int  <= w_int;
      end
    end
  end

  fpu_round_inc u_round_inc (
    .i_lsb    (r_s1_int[0]),
    .i_guard  (r_s1_g),
    .i_sticky (r_s1_s),
    .i_sign   (r_s1_sign),
    .i_rm     (r_s1_rm),
    .o_inc    (w_inc)
  );

  assign w_inexact = r_s1_g | r_s1_s;
  assign w_mag     = {1'b0, r_s1_int} + {{OUT_W{1'b0}}, w_inc};
  assign w_neg     = ~w_mag[OUT_W-1:0] + {{(OUT_W-1){1'b0}}, 1'b1};
  assign w_pos_ovf = w_mag[OUT_W] | w_mag[OUT_W-1];
  // -2^(OUT_W-1) itself is representable, so only magnitudes beyond it overflow
  assign w_neg_ovf = w_mag[OUT_W] | (w_mag[OUT_W-1] & (|w_mag[OUT_W-2:0]));

  // Stage-2 range check and saturation after rounding
  always_comb begin
    w_y     = '0;
    w_flags = '0;
    if (r_s1_nan) begin
      w_y        = r_s1_uns ? UMAX : SMAX;
      w_flags.nv = 1'b1;
    end else if (r_s1_ovf) begin
      w_flags.nv = 1'b1;
      if (r_s1_uns) begin
        w_y = r_s1_sign ? '0 : UMAX;
      end else begin
        w_y = r_s1_sign ? SMIN : SMAX;
      end
    end else if (r_s1_uns) begin
      if (r_s1_sign & (|w_mag)) begin
        w_flags.nv = 1'b1;
      end else if (r_s1_sign) begin
        w_flags.nx = w_inexact;
      end else if (w_mag[OUT_W]) begin
        w_y        = UMAX;
        w_flags.nv = 1'b1;
      end else begin
        w_y        = w_mag[OUT_W-1:0];
        w_flags.nx = w_inexact;
      end
    end else if (r_s1_sign) begin
      if (w_neg_ovf) begin
        w_y        = SMIN;
        w_flags.nv = 1'b1;
      end else begin
        w_y        = w_neg;
        w_flags.nx = w_inexact;
      end
    end else begin
      if (w_pos_ovf) begin
        w_y        = SMAX;
        w_flags.nv = 1'b1;
      end else begin
        w_y        = w_mag[OUT_W-1:0];
        w_flags.nx = w_inexact;
      end
    end
  end

  // Stage-2 output register: holds while the consumer stalls
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
      r_flags     <= '0;
    end else if (w_s1_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y     <= w_y;
        r_flags <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fpu_ftoi_pipe.sv
// Directed bench for fpu_ftoi_pipe: 32-bit and 16-bit instances share stimulus.
module tb_fpu_ftoi_pipe;
  import fpu_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] x = 32'h0;
  logic [1:0]  rm = 2'b00;
  logic        uns = 1'b0;

  logic        ir32, ov32, nv32, nx32;
  logic [31:0] y32;
  logic        ir16, ov16, nv16, nx16;
  logic [15:0] y16;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_ftoi_pipe #(.OUT_W(32), .FLUSH_SUB(1'b1)) dut32 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir32), .x(x), .rm(rm),
    .uns(uns), .out_valid(ov32), .out_ready(out_ready), .y(y32),
    .flag_nv(nv32), .flag_nx(nx32)
  );

  fpu_ftoi_pipe #(.OUT_W(16), .FLUSH_SUB(1'b1)) dut16 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(ir16), .x(x), .rm(rm),
    .uns(uns), .out_valid(ov16), .out_ready(out_ready), .y(y16),
    .flag_nv(nv16), .flag_nx(nx16)
  );

  // One op through an idle pipe; lat counts edges from the handshake edge (incl.) to out_valid
  task automatic do_op(input logic [31:0] xv, input logic [1:0] rmv, input logic uv,
                       output logic [31:0] ry32, output logic [1:0] rf32,
                       output logic [15:0] ry16, output logic [1:0] rf16, output int lat);
    x = xv; rm = rmv; uns = uv; in_valid = 1'b1; out_ready = 1'b1;
    lat = 99; ry32 = '0; rf32 = '0; ry16 = '0; rf16 = '0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (ov32) begin
        lat = i; ry32 = y32; rf32 = {nv32, nx32}; ry16 = y16; rf16 = {nv16, nx16};
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    #12;
    checks++;
    if (ov32 !== 1'b0 || y32 !== 32'h0 || {nv32, nx32} !== 2'b00) begin
      failures++;
      $display("FAIL reset_state ov=%b y=%h fl=%b want ov=0 y=0 fl=00", ov32, y32, {nv32, nx32});
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release in_ready=%b ov=%b want 1/0", ir32, ov32);
    end
  endtask

  task automatic test_rne;
    logic [31:0] tx [0:2] = '{32'h40200000, 32'h40600000, 32'h3F000000};
    logic [31:0] ey [0:2] = '{32'd2, 32'd4, 32'd0};
    logic [31:0] ry; logic [1:0] rf; logic [15:0] r16; logic [1:0] f16; int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(tx[i], RM_RNE, 1'b0, ry, rf, r16, f16, lat);
      checks++;
      if (ry !== ey[i] || rf !== 2'b01 || lat != 2) begin
        failures++;
        $display("FAIL rne[%0d] y=%h fl=%b lat=%0d want y=%h fl=01 lat=2", i, ry, rf, lat, ey[i]);
      end
    end
  endtask

  task automatic test_modes;
    logic [1:0]  tm [0:3] = '{RM_RTZ, RM_RDN, RM_RUP, RM_RNE};
    logic [31:0] ey [0:3] = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFE};
    logic [31:0] ry; logic [1:0] rf; logic [15:0] r16; logic [1:0] f16; int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(32'hC0200000, tm[i], 1'b0, ry, rf, r16, f16, lat);
      checks++;
      if (ry !== ey[i] || rf !== 2'b01 || lat != 2) begin
        failures++;
        $display("FAIL mode_m2p5[%0d] y=%h fl=%b lat=%0d want y=%h fl=01", i, ry, rf, lat, ey[i]);
      end
    end
  endtask

  task automatic test_range;
    logic [31:0] tx [0:6] = '{32'h4F000000, 32'hCF000000, 32'h7FC00000, 32'h4F000000,
                              32'hFF800000, 32'h7F800000, 32'h80000000};
    logic        tu [0:6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ey [0:6] = '{32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000000,
                              32'h80000000, 32'hFFFFFFFF, 32'h00000000};
    logic [1:0]  ef [0:6] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00};
    logic [31:0] ry; logic [1:0] rf; logic [15:0] r16; logic [1:0] f16; int lat;
    for (int i = 0; i < 7; i++) begin
      do_op(tx[i], RM_RTZ, tu[i], ry, rf, r16, f16, lat);
      checks++;
      if (ry !== ey[i] || rf !== ef[i] || lat != 2) begin
        failures++;
        $display("FAIL range[%0d] y=%h fl=%b lat=%0d want y=%h fl=%b", i, ry, rf, lat, ey[i], ef[i]);
      end
    end
  endtask

  task automatic test_unsigned;
    logic [31:0] ry; logic [1:0] rf; logic [15:0] r16; logic [1:0] f16; int lat;
    do_op(32'hBE99999A, RM_RTZ, 1'b1, ry, rf, r16, f16, lat);
    checks++;
    if (ry !== 32'h0 || rf !== 2'b01) begin
      failures++;
      $display("FAIL uns_m0p3 y=%h fl=%b want y=0 fl=01", ry, rf);
    end
    do_op(32'hBF800000, RM_RTZ, 1'b1, ry, rf, r16, f16, lat);
    checks++;
    if (ry !== 32'h0 || rf !== 2'b10) begin
      failures++;
      $display("FAIL uns_m1 y=%h fl=%b want y=0 fl=10", ry, rf);
    end
  endtask

  task automatic test_ovf16;
    logic [1:0]  tm [0:2] = '{RM_RNE, RM_RTZ, RM_RTZ};
    logic [31:0] tx [0:2] = '{32'h46FFFF00, 32'h46FFFF00, 32'h4F000000};
    logic [15:0] ey [0:2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF};
    logic [1:0]  ef [0:2] = '{2'b10, 2'b01, 2'b10};
    logic [31:0] ry; logic [1:0] rf; logic [15:0] r16; logic [1:0] f16; int lat;
    for (int i = 0; i < 3; i++) begin
      do_op(tx[i], tm[i], 1'b0, ry, rf, r16, f16, lat);
      checks++;
      if (r16 !== ey[i] || f16 !== ef[i]) begin
        failures++;
        $display("FAIL ovf16[%0d] y=%h fl=%b want y=%h fl=%b", i, r16, f16, ey[i], ef[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] vin [0:5] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                               32'h40800000, 32'h40A00000, 32'h40C00000};
    logic [6:0]  pat = 7'b1011001;
    int sent = 0; int recv = 0;
    logic saw_full = 1'b0; logic held = 1'b0; logic [31:0] held_y = '0;
    logic do_in, do_out;
    for (int c = 0; c < 60 && recv < 6; c++) begin
      out_ready = pat[c % 7];
      in_valid = (sent < 6);
      x = vin[(sent < 6) ? sent : 5]; rm = RM_RTZ; uns = 1'b0;
      #1;
      if (held) begin
        checks++;
        if (y32 !== held_y || ov32 !== 1'b1) begin
          failures++;
          $display("FAIL b2b_stall_hold y=%h ov=%b want y=%h ov=1", y32, ov32, held_y);
        end
      end
      if (in_valid && !ir32) saw_full = 1'b1;
      do_in = in_valid && ir32;
      do_out = ov32 && out_ready;
      if (do_out) begin
        checks++;
        if (y32 !== 32'(recv + 1) || {nv32, nx32} !== 2'b00) begin
          failures++;
          $display("FAIL b2b_result[%0d] y=%h fl=%b want y=%h fl=00", recv, y32, {nv32, nx32}, 32'(recv + 1));
        end
        recv++;
      end
      held = ov32 && !out_ready;
      held_y = y32;
      if (do_in) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (recv != 6 || sent != 6) begin
      failures++;
      $display("FAIL b2b_count recv=%0d sent=%0d want 6/6", recv, sent);
    end
    checks++;
    if (!saw_full) begin
      failures++;
      $display("FAIL b2b_in_ready_low saw=%b want 1", saw_full);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (ov32 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_no_dup ov=%b want 0", ov32);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] ry; logic [1:0] rf; logic [15:0] r16; logic [1:0] f16; int lat;
    out_ready = 1'b0; in_valid = 1'b1; x = 32'h3F800000; rm = RM_RTZ; uns = 1'b0;
    @(posedge clk); #1;
    x = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (ov32 !== 1'b1 || ir32 !== 1'b0) begin
      failures++;
      $display("FAIL mid_full ov=%b in_ready=%b want 1/0", ov32, ir32);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (ov32 !== 1'b0 || y32 !== 32'h0 || {nv32, nx32} !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset ov=%b y=%h fl=%b want 0/0/00", ov32, y32, {nv32, nx32});
    end
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
      failures++;
      $display("FAIL mid_release in_ready=%b ov=%b want 1/0", ir32, ov32);
    end
    do_op(32'h40400000, RM_RTZ, 1'b0, ry, rf, r16, f16, lat);
    checks++;
    if (ry !== 32'd3 || rf !== 2'b00 || lat != 2) begin
      failures++;
      $display("FAIL mid_next_op y=%h fl=%b lat=%0d want y=3 fl=00 lat=2", ry, rf, lat);
    end
  endtask

  initial begin
    test_reset();
    test_rne();
    test_modes();
    test_range();
    test_unsigned();
    test_ovf16();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fpu_ftoi_pipe.md
Name: fpu_ftoi_pipe

Overview:
Pipelined, parametrised converter from IEEE-754 binary32 to a signed or unsigned OUT_W-bit integer. It supports four rounding modes, saturates out-of-range and NaN inputs, and reports invalid/inexact flags. Two register stages with valid/ready handshake on both sides let it sit directly in the FPU issue/writeback path under backpressure.

Parameters:
OUT_W, 32, integer result width; legal values 16, 32, 64.
FLUSH_SUB, 1, 1 = subnormal inputs read as exact zero; 0 = subnormals converted normally (always rounding-relevant only).

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
in_valid  in  1  input operand valid
in_ready  out  1  block can accept operand this cycle
x  in  32  binary32 operand
rm  in  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (floor), 11 RUP (ceil)
uns  in  1  1 = unsigned result, 0 = two's-complement signed
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result this cycle
y  out  OUT_W  integer result
flag_nv  out  1  invalid: NaN, ±Inf, or rounded value out of range
flag_nx  out  1  inexact: result differs from input, only when flag_nv=0

Behaviour:
- Reset (rstn low, asynchronous): s1_valid, s2_valid, out_valid = 0; y, flag_nv, flag_nx = 0; in_ready = 1 after release. Reset mid-operation discards in-flight ops, with no partial outputs.
- Transfer occurs on a rising clk with valid&ready. x, rm, uns are captured together; rm/uns apply per operation.
- Stage 1 (decode/align): sign, exponent, mantissa with hidden bit. Right-shift into an OUT_W-bit integer part plus guard bit and sticky OR of all lower bits. Exponent below -1 gives integer 0, guard 0, sticky = (x≠±0). Exponent ≥ OUT_W sets pre-overflow. NaN (exp 255, mant≠0) and Inf are tagged.
- Stage 2 (round/saturate): increment = RNE: g&(s|lsb); RTZ: 0; RDN: sign&(g|s); RUP: ~sign&(g|s). Compute an OUT_W+1-bit magnitude, then check range after rounding.
- Signed range: [-2^(OUT_W-1), 2^(OUT_W-1)-1]. Unsigned range: [0, 2^OUT_W-1].
- Saturation, with flag_nv=1 and flag_nx=0:
  - NaN and +Inf/+overflow: signed → 2^(OUT_W-1)-1; unsigned → all ones.
  - -Inf/-overflow: signed → -2^(OUT_W-1); unsigned → 0.
  - Unsigned negative input whose rounded magnitude ≠ 0: 0 with nv.
- Negative values that round to 0 give 0, nx only, in both modes. ±0 gives 0 with no flags.
- Latency: exactly 2 cycles from input handshake to out_valid when unstalled. Throughput is 1 per cycle.
- Stall rule: stage 2 holds when out_valid & ~out_ready. Stage 1 advances iff ~s2_valid | out_ready. in_ready = ~s1_valid | s1_advance, which is combinational from out_ready; there is no combinational path from in_valid.
- y and flags are stable while out_valid & ~out_ready.
- Simultaneous accept and drain in the same cycle must not drop or duplicate an operation. A full pipeline holds 2 ops.

Decomposition:
- The shared package fpu_pkg holds:
  - rounding-mode encodings RM_RNE/RTZ/RDN/RUP;
  - binary32 field constants (BIAS=127, EXP_W=8, MAN_W=23);
  - a typedef for the {nv,nx} flag pair reused by other FPU ops.
- One natural sub-module, fpu_round_inc: combinational (lsb, guard, sticky, sign, rm) → increment bit. It is shared with itof/fadd rounding.

Test Plan:
- RNE ties: x=0x40200000 (2.5) → y=2, nx=1; x=0x40600000 (3.5) → y=4, nx=1; x=0x3F000000 (0.5) → 0, nx=1.
- Directed modes on -2.5 (0xC0200000), signed 32: RTZ → 0xFFFFFFFE; RDN → 0xFFFFFFFD; RUP → 0xFFFFFFFE; all with nx=1.
- Range edges, signed 32, RTZ:
  - 0x4F000000 (2^31) → 0x7FFFFFFF, nv=1.
  - 0xCF000000 (-2^31) → 0x80000000, no flags.
  - 0x7FC00000 (NaN) → 0x7FFFFFFF, nv=1.
  - Same 0x4F000000 with uns=1 → 0x80000000, no flags.
- Unsigned negatives: 0xBE99999A (-0.3) uns=1 RTZ → 0, nx=1, nv=0. 0xBF800000 (-1.0) uns=1 → 0, nv=1.
- Post-round overflow at OUT_W=16, signed: 0x46FFFF00 (32767.5) RNE → 0x7FFF, nv=1; same input RTZ → 0x7FFF, nx=1, nv=0.
- Handshake: stream 6 ops back-to-back while out_ready toggles 1,0,0,1,1,0,1…. Required: in_ready falls after 2 ops held; results emerge in order with no loss or duplication; y stable while stalled. Assert rstn low mid-stream → out_valid=0 immediately, and the next op after release completes in 2 cycles.
